muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/result bundle for the iterative multiply/divide unit.
// The master issues operations and register writes; the slave is the unit itself.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wdata,
        input  busy, done, dz, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wdata,
        output busy, done, dz, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with hi/lo result registers.
// One shift-add or restoring shift-subtract step per busy cycle; signs via magnitude + final negate.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic             busy_o;
    logic             done_o;
    logic             dz_o;
    logic             accept;
    logic             last_step;

    logic [CNT_W-1:0] count;
    logic             is_div_q;
    logic             neg_lo_q;
    logic             neg_hi_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH:0]   acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH:0]     step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   rem_mag;
    logic [WIDTH-1:0]   quo_fin;
    logic [WIDTH-1:0]   rem_fin;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = BUSY;
            BUSY:    if (last_step) state_next = DONE;
            DONE:    state_next = bus.start ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state == BUSY);
        done_o = (state == DONE);
        dz_o   = (state == DONE) && div_zero_q;
        accept = bus.start && (state != BUSY);
    end

    assign last_step = (count == CNT_W'(WIDTH - 1));

    // Operand magnitudes; only the signed ops (op[0]=1) see a sign bit.
    always_comb begin
        sign_a = bus.op[0] & bus.a[WIDTH-1];
        sign_b = bus.op[0] & bus.b[WIDTH-1];
        mag_a  = sign_a ? -bus.a : bus.a;
        mag_b  = sign_b ? -bus.b : bus.b;
    end

    // acc_hi/acc_lo hold the partial product for mul, remainder/quotient for div.
    always_comb begin
        addend    = acc_lo_q[0] ? mcand_q : {WIDTH{1'b0}};
        mul_sum   = acc_hi_q + {1'b0, addend};
        div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        div_diff  = div_shift - {1'b0, mcand_q};
        if (is_div_q) begin
            step_hi = div_ge ? div_diff : div_shift;
            step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = {1'b0, mul_sum[WIDTH:1]};
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod     = {step_hi[WIDTH-1:0], step_lo};
        prod_fin = neg_lo_q ? -prod : prod;
        rem_mag  = step_hi[WIDTH-1:0];
        quo_fin  = neg_lo_q ? -step_lo : step_lo;
        rem_fin  = neg_hi_q ? -rem_mag : rem_mag;
        res_hi   = is_div_q ? rem_fin : prod_fin[2*WIDTH-1:WIDTH];
        res_lo   = is_div_q ? quo_fin : prod_fin[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
            mcand_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
        end else if (accept) begin
            count      <= '0;
            is_div_q   <= bus.op[1];
            neg_lo_q   <= sign_a ^ sign_b;
            neg_hi_q   <= sign_a;
            div_zero_q <= bus.op[1] && (bus.b == '0);
            mcand_q    <= bus.op[1] ? mag_b : mag_a;
            acc_hi_q   <= '0;
            acc_lo_q   <= bus.op[1] ? mag_a : mag_b;
        end else if (busy_o) begin
            count    <= count + 1'b1;
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
        end
    end

    // Results land on the final step; a zero divisor leaves hi/lo untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (busy_o) begin
            if (last_step && !div_zero_q) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else begin
            if (bus.wr_hi) hi_q <= bus.wdata;
            if (bus.wr_lo) lo_q <= bus.wdata;
        end
    end

    assign bus.busy = busy_o;
    assign bus.done = done_o;
    assign bus.dz   = dz_o;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected hi/lo/dz are queued at issue
// and popped by a monitor on every done pulse.
module tb_muldiv_unit;
    localparam int W   = 32;
    localparam int LAT = W + 1;
    localparam int TMO = 100;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t         sb[$];
    int           n_compared   = 0;
    int           n_mismatched = 0;
    logic [W-1:0] model_hi     = '0;
    logic [W-1:0] model_lo     = '0;

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] cur_hi, input logic [W-1:0] cur_lo);
        exp_t                  e;
        logic [2*W-1:0]        p;
        logic signed [2*W-1:0] sop_a;
        logic signed [2*W-1:0] sop_b;
        logic signed [2*W-1:0] q;
        logic signed [2*W-1:0] r;
        e.hi  = cur_hi;
        e.lo  = cur_lo;
        e.dz  = 1'b0;
        sop_a = {{W{a[W-1]}}, a};
        sop_b = {{W{b[W-1]}}, b};
        case (op)
            2'b00: begin
                p    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.hi = p[2*W-1:W];
                e.lo = p[W-1:0];
            end
            2'b01: begin
                p    = sop_a * sop_b;
                e.hi = p[2*W-1:W];
                e.lo = p[W-1:0];
            end
            2'b10: begin
                if (b == '0) e.dz = 1'b1;
                else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            default: begin
                if (b == '0) e.dz = 1'b1;
                else begin
                    q    = sop_a / sop_b;
                    r    = sop_a % sop_b;
                    e.lo = q[W-1:0];
                    e.hi = r[W-1:0];
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1 && bus.done === 1'b1) begin
            n_compared++;
            if (sb.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL unexpected_done: done=1 at %0t, required no pending operation", $time);
            end else begin
                e = sb.pop_front();
                if (bus.hi !== e.hi) begin
                    n_mismatched++;
                    $display("[TB] FAIL sb_hi: got %h expected %h", bus.hi, e.hi);
                end
                n_compared++;
                if (bus.lo !== e.lo) begin
                    n_mismatched++;
                    $display("[TB] FAIL sb_lo: got %h expected %h", bus.lo, e.lo);
                end
                n_compared++;
                if (bus.dz !== e.dz) begin
                    n_mismatched++;
                    $display("[TB] FAIL sb_dz: got %b expected %b", bus.dz, e.dz);
                end
            end
        end else if (rst !== 1'b1) begin
            n_compared++;
            if (bus.dz !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL dz_outside_done: got %b expected 0 at %0t", bus.dz, $time);
            end
        end
    end

    // Drives start for one cycle and queues the model's expectation.
    task automatic apply_stimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e = model(op, a, b, model_hi, model_lo);
        model_hi = e.hi;
        model_lo = e.lo;
        sb.push_back(e);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Returns at the negedge of the done cycle; lat counts cycles from the calling cycle.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) return;
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = '1;
        bus.b     = '1;
        bus.wr_hi = 1'b1;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        n_compared++; if (bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        n_compared++; if (bus.done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        n_compared++; if (bus.dz !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_dz: got %b expected 0", bus.dz); end
        n_compared++; if (bus.hi !== '0) begin n_mismatched++; $display("[TB] FAIL reset_hi: got %h expected 0", bus.hi); end
        n_compared++; if (bus.lo !== '0) begin n_mismatched++; $display("[TB] FAIL reset_lo: got %h expected 0", bus.lo); end
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        @(posedge clk);
        #1;
        n_compared++; if (bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL post_reset_idle: got busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_multu;
        int lat, bc;
        apply_stimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        n_compared++; if (lat !== LAT) begin n_mismatched++; $display("[TB] FAIL multu_latency: got %0d expected %0d", lat, LAT); end
        n_compared++; if (bc !== W) begin n_mismatched++; $display("[TB] FAIL multu_busy_cycles: got %0d expected %0d", bc, W); end
        n_compared++; if (bus.hi !== 32'hFFFF_FFFE) begin n_mismatched++; $display("[TB] FAIL multu_hi: got %h expected fffffffe", bus.hi); end
        n_compared++; if (bus.lo !== 32'h0000_0001) begin n_mismatched++; $display("[TB] FAIL multu_lo: got %h expected 00000001", bus.lo); end
    endtask

    task automatic test_mult;
        int lat, bc;
        apply_stimulus(2'b01, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, bc);
        n_compared++; if (lat !== LAT) begin n_mismatched++; $display("[TB] FAIL mult_latency: got %0d expected %0d", lat, LAT); end
        n_compared++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_mismatched++; $display("[TB] FAIL mult_neg3x5: got %h_%h expected ffffffff_fffffff1", bus.hi, bus.lo); end
        apply_stimulus(2'b01, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat, bc);
        n_compared++; if ({bus.hi, bus.lo} !== 64'h4000_0000_0000_0000) begin n_mismatched++; $display("[TB] FAIL mult_minsq: got %h_%h expected 40000000_00000000", bus.hi, bus.lo); end
    endtask

    task automatic test_div;
        int lat, bc;
        apply_stimulus(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bc);
        n_compared++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_mismatched++; $display("[TB] FAIL div_neg7by2: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", bus.hi, bus.lo); end
        apply_stimulus(2'b10, 32'd7, 32'd2);
        wait_done(lat, bc);
        n_compared++; if ({bus.hi, bus.lo} !== {32'd1, 32'd3}) begin n_mismatched++; $display("[TB] FAIL divu_7by2: got hi=%h lo=%h expected hi=1 lo=3", bus.hi, bus.lo); end
        apply_stimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        n_compared++; if (lat !== LAT) begin n_mismatched++; $display("[TB] FAIL div_latency: got %0d expected %0d", lat, LAT); end
        n_compared++; if ({bus.hi, bus.lo, bus.dz} !== {32'h0, 32'h8000_0000, 1'b0}) begin n_mismatched++; $display("[TB] FAIL div_overflow: got hi=%h lo=%h dz=%b expected hi=0 lo=80000000 dz=0", bus.hi, bus.lo, bus.dz); end
    endtask

    task automatic test_div_by_zero;
        int lat, bc;
        @(posedge clk);
        #1;
        bus.wr_hi = 1'b1;
        bus.wdata = 32'h1234;
        model_hi  = 32'h1234;
        @(posedge clk);
        #1;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'h5678;
        model_lo  = 32'h5678;
        @(posedge clk);
        #1;
        bus.wr_lo = 1'b0;
        n_compared++; if (bus.hi !== 32'h1234) begin n_mismatched++; $display("[TB] FAIL mthi: got %h expected 00001234", bus.hi); end
        n_compared++; if (bus.lo !== 32'h5678) begin n_mismatched++; $display("[TB] FAIL mtlo: got %h expected 00005678", bus.lo); end
        apply_stimulus(2'b10, 32'd9, 32'd0);
        wait_done(lat, bc);
        n_compared++; if (lat !== LAT) begin n_mismatched++; $display("[TB] FAIL dz_latency: got %0d expected %0d", lat, LAT); end
        n_compared++; if ({bus.dz, bus.hi, bus.lo} !== {1'b1, 32'h1234, 32'h5678}) begin n_mismatched++; $display("[TB] FAIL dz_result: got dz=%b hi=%h lo=%h expected dz=1 hi=1234 lo=5678", bus.dz, bus.hi, bus.lo); end
        @(posedge clk);
        #1;
        n_compared++; if ({bus.done, bus.dz} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL dz_one_cycle: got done=%b dz=%b expected 0 0", bus.done, bus.dz); end
    endtask

    task automatic test_write_with_start;
        int lat, bc;
        bus.wr_hi = 1'b1;
        bus.wdata = 32'hAAAA;
        model_hi  = 32'hAAAA;
        apply_stimulus(2'b00, 32'd2, 32'd3);
        bus.wr_hi = 1'b0;
        n_compared++; if (bus.hi !== 32'hAAAA) begin n_mismatched++; $display("[TB] FAIL write_with_start: got hi=%h expected 0000aaaa", bus.hi); end
        wait_done(lat, bc);
        n_compared++; if ({bus.hi, bus.lo} !== {32'd0, 32'd6}) begin n_mismatched++; $display("[TB] FAIL write_overwritten: got hi=%h lo=%h expected hi=0 lo=6", bus.hi, bus.lo); end
    endtask

    task automatic test_start_while_busy;
        int lat, bc, dones;
        @(posedge clk);
        #1;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'h1111;
        model_lo  = 32'h1111;
        @(posedge clk);
        #1;
        bus.wr_lo = 1'b0;
        apply_stimulus(2'b10, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'hDEAD;
        @(posedge clk);
        #1;
        bus.wr_lo = 1'b0;
        n_compared++; if ({bus.busy, bus.lo} !== {1'b1, 32'h1111}) begin n_mismatched++; $display("[TB] FAIL busy_write_ignored: got busy=%b lo=%h expected busy=1 lo=00001111", bus.busy, bus.lo); end
        wait_done(lat, bc);
        n_compared++; if (lat !== LAT - 6) begin n_mismatched++; $display("[TB] FAIL busy_start_latency: got %0d expected %0d", lat, LAT - 6); end
        n_compared++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin n_mismatched++; $display("[TB] FAIL divu_100by7: got hi=%h lo=%h expected hi=2 lo=14", bus.hi, bus.lo); end
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        n_compared++; if (dones !== 0) begin n_mismatched++; $display("[TB] FAIL busy_start_queued: got %0d extra done pulses expected 0", dones); end
    endtask

    task automatic test_reset_during_busy;
        int lat, bc, dones;
        apply_stimulus(2'b00, 32'd1000, 32'd1000);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        model_hi = '0;
        model_lo = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_compared++; if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'd0, 32'd0}) begin n_mismatched++; $display("[TB] FAIL reset_abort: got busy=%b hi=%h lo=%h expected 0 0 0", bus.busy, bus.hi, bus.lo); end
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        n_compared++; if (dones !== 0) begin n_mismatched++; $display("[TB] FAIL reset_no_done: got %0d done pulses expected 0", dones); end
        apply_stimulus(2'b00, 32'd6, 32'd7);
        wait_done(lat, bc);
        n_compared++; if (lat !== LAT) begin n_mismatched++; $display("[TB] FAIL fresh_latency: got %0d expected %0d", lat, LAT); end
        n_compared++; if ({bus.hi, bus.lo} !== {32'd0, 32'd42}) begin n_mismatched++; $display("[TB] FAIL fresh_6x7: got hi=%h lo=%h expected hi=0 lo=42", bus.hi, bus.lo); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(2'b01, 32'hFFFF_0000 + 32'(i), 32'd12345);
            n_compared++; if ({bus.busy, bus.done} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL b2b_accept: got busy=%b done=%b expected 1 0", bus.busy, bus.done); end
            wait_done(lat, bc);
            n_compared++; if (lat !== LAT) begin n_mismatched++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", lat, LAT); end
        end
    endtask

    task automatic test_random;
        int           lat, bc;
        logic [W-1:0] edges [4];
        logic [W-1:0] a, b;
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h0000_0001;
        edges[2] = 32'h8000_0000;
        edges[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 14; i++) begin
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 5) == 0) b = '0;
            apply_stimulus(2'($urandom_range(0, 3)), a, b);
            wait_done(lat, bc);
            n_compared++; if (lat !== LAT) begin n_mismatched++; $display("[TB] FAIL random_latency: got %0d expected %0d", lat, LAT); end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wdata = '0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_by_zero();
        test_write_with_start();
        test_start_while_busy();
        test_reset_during_busy();
        test_back_to_back();
        test_random();
        repeat (3) @(posedge clk);
        #1;
        n_compared++;
        if (sb.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL pending_results: got %0d outstanding expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
